// File: rtl/main_memory_responder_pkg.sv
// Shared definitions for the cache/main-memory handshake: geometry defaults,
// FSM state encoding and width helpers. The cache controller imports the
// same defaults so both sides agree on block geometry.
package main_memory_responder_pkg;

    // Default geometry shared with the cache controller
    localparam int DEF_ADDR_W      = 10;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_BLOCK_WORDS = 4;

    // 3-bit state encoding for the responder FSM
    localparam logic [2:0] ST_IDLE_ENC     = 3'd0;
    localparam logic [2:0] ST_RD_WAIT_ENC  = 3'd1;
    localparam logic [2:0] ST_RD_BURST_ENC = 3'd2;
    localparam logic [2:0] ST_WR_WAIT_ENC  = 3'd3;
    localparam logic [2:0] ST_TURN_ENC     = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE_ENC,
        RD_WAIT  = ST_RD_WAIT_ENC,
        RD_BURST = ST_RD_BURST_ENC,
        WR_WAIT  = ST_WR_WAIT_ENC,
        TURN     = ST_TURN_ENC
    } state_t;

    // Ceiling log2; clog2(1) = 0
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Word-offset field width, never narrower than one bit
    function automatic int idx_width(input int block_words);
        return (clog2(block_words) < 1) ? 1 : clog2(block_words);
    endfunction

endpackage

// File: rtl/main_memory_responder_if.sv
// Cache <-> main-memory request/refill handshake bundle.
// master: cache controller (drives main_read/main_write/addr/wdata).
// slave: memory responder (drives rdata/rvalid/rword_idx/ready/busy/protocol_err).
interface main_memory_responder_if
    import main_memory_responder_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS
) ();

    localparam int IDX_W = idx_width(BLOCK_WORDS);

    logic              main_read;
    logic              main_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic [IDX_W-1:0]  rword_idx;
    logic              ready;
    logic              busy;
    logic              protocol_err;

    modport master (
        output main_read, main_write, addr, wdata,
        input  rdata, rvalid, rword_idx, ready, busy, protocol_err
    );

    modport slave (
        input  main_read, main_write, addr, wdata,
        output rdata, rvalid, rword_idx, ready, busy, protocol_err
    );

endinterface

// File: rtl/main_memory_responder_mem_array.sv
// Single-port synchronous word RAM backing main memory.
// Latency: one cycle, read data registered; write lands at the clock edge.
// No backpressure: one access per cycle, write and read never issued together.
// Ports: clk/reset, we/re/addr/wdata request, q registered read data
// (q clears on reset; the storage itself is never cleared).
module main_mem_array #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] q
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Output register doubles as the responder's rdata register
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (re) begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/main_memory_responder.sv
// Main-memory responder: single-word writes and block refills for the cache.
// Latency: first refill beat READ_LATENCY cycles after acceptance, write commit
// and ready WRITE_LATENCY cycles after acceptance; one TURN cycle afterwards.
// Backpressure: the initiator holds its request until ready; busy covers the op.
// Ports: clk, reset (sync, active high), bus (slave side of the handshake).
module main_memory_responder
    import main_memory_responder_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int BLOCK_WORDS   = DEF_BLOCK_WORDS,
    parameter int READ_LATENCY  = 3,
    parameter int WRITE_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    main_memory_responder_if.slave bus
);

    localparam int IDX_W   = idx_width(BLOCK_WORDS);
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = (clog2(MAX_LAT + 1) < 1) ? 1 : clog2(MAX_LAT + 1);

    localparam logic [ADDR_W-1:0] BLK_MASK  = ~(ADDR_W'(BLOCK_WORDS - 1));
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BLOCK_WORDS - 1);
    localparam logic [CNT_W-1:0]  RD_LOAD   = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0]  WR_LOAD   = CNT_W'(WRITE_LATENCY - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  base_q, base_d;     // block base for reads, word address for writes
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               rvalid_q, rvalid_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               perr_q, perr_d;

    logic               mem_we, mem_re;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  mem_q;
    logic [IDX_W-1:0]   beat_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            base_q   <= '0;
            wdata_q  <= '0;
            rvalid_q <= 1'b0;
            idx_q    <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            wdata_q  <= wdata_d;
            rvalid_q <= rvalid_d;
            idx_q    <= idx_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            perr_q   <= perr_d;
        end
    end

    // Every RAM read is issued one cycle ahead of its beat so the RAM output
    // register lines up with rvalid/rword_idx; ready is set on the edge that
    // issues the last beat (reads) or commits the word (writes).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        wdata_d   = wdata_q;
        rvalid_d  = 1'b0;
        idx_d     = idx_q;
        ready_d   = 1'b0;
        busy_d    = busy_q;
        perr_d    = perr_q;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = base_q;
        mem_wdata = wdata_q;
        beat_next = idx_q + IDX_W'(1);

        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (bus.main_read && bus.main_write) begin
                    perr_d = 1'b1;
                end else if (bus.main_read) begin
                    base_d = bus.addr & BLK_MASK;
                    busy_d = 1'b1;
                    if (READ_LATENCY == 1) begin
                        mem_re   = 1'b1;
                        mem_addr = bus.addr & BLK_MASK;
                        rvalid_d = 1'b1;
                        ready_d  = (BLOCK_WORDS == 1);
                        state_d  = RD_BURST;
                    end else begin
                        cnt_d   = RD_LOAD;
                        state_d = RD_WAIT;
                    end
                end else if (bus.main_write) begin
                    base_d  = bus.addr;
                    wdata_d = bus.wdata;
                    busy_d  = 1'b1;
                    cnt_d   = WR_LOAD;
                    state_d = WR_WAIT;
                    if (WRITE_LATENCY == 1) begin
                        mem_we    = 1'b1;
                        mem_addr  = bus.addr;
                        mem_wdata = bus.wdata;
                        ready_d   = 1'b1;
                    end
                end
            end

            RD_WAIT: begin
                if (cnt_q == CNT_ONE) begin
                    cnt_d    = '0;
                    mem_re   = 1'b1;
                    mem_addr = base_q;
                    rvalid_d = 1'b1;
                    idx_d    = '0;
                    ready_d  = (BLOCK_WORDS == 1);
                    state_d  = RD_BURST;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            RD_BURST: begin
                if (idx_q == LAST_IDX) begin
                    // Last beat is on the outputs now; burst ends here
                    busy_d  = 1'b0;
                    idx_d   = '0;
                    state_d = TURN;
                end else begin
                    // Base is block aligned, so OR-ing the offset never carries out of the block
                    mem_re   = 1'b1;
                    mem_addr = base_q | ADDR_W'(beat_next);
                    rvalid_d = 1'b1;
                    idx_d    = beat_next;
                    ready_d  = (beat_next == LAST_IDX);
                end
            end

            WR_WAIT: begin
                if (cnt_q == '0) begin
                    // ready cycle: commit already happened on the previous edge
                    busy_d  = 1'b0;
                    state_d = TURN;
                end else if (cnt_q == CNT_ONE) begin
                    mem_we  = 1'b1;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            TURN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset on a commit edge must drop the write, so gate the RAM strobes
    main_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we & ~reset),
        .re    (mem_re & ~reset),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .q     (mem_q)
    );

    assign bus.rdata        = mem_q;
    assign bus.rvalid       = rvalid_q;
    assign bus.rword_idx    = idx_q;
    assign bus.ready        = ready_q;
    assign bus.busy         = busy_q;
    assign bus.protocol_err = perr_q;

endmodule

// File: tb/tb_main_memory_responder.sv
module tb_main_memory_responder;

    localparam int RL = 3;
    localparam int WL = 2;
    localparam int BW = 4;

    typedef struct packed {
        logic             wr;
        logic [9:0]       a;
        logic [31:0]      d;
        logic [3:0][31:0] e;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    vec_t vecs [18];

    main_memory_responder_if #(.ADDR_W(10), .DATA_W(32), .BLOCK_WORDS(4)) bus ();

    main_memory_responder #(
        .ADDR_W        (10),
        .DATA_W        (32),
        .BLOCK_WORDS   (4),
        .READ_LATENCY  (3),
        .WRITE_LATENCY (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [9:0] a, input logic [31:0] d,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2, input logic [31:0] e3);
        vec_t v;
        v.wr   = wr;
        v.a    = a;
        v.d    = d;
        v.e[0] = e0;
        v.e[1] = e1;
        v.e[2] = e2;
        v.e[3] = e3;
        return v;
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_rvalid"}, 32'(bus.rvalid), 32'd0);
        chk({tag, "_ready"},  32'(bus.ready),  32'd0);
        chk({tag, "_busy"},   32'(bus.busy),   32'd0);
    endtask

    // Cycle T is the negedge where the request is driven; samples at later negedges
    task automatic do_write(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.main_write = 1'b1;
        bus.addr       = a;
        bus.wdata      = d;
        for (int k = 1; k <= WL; k++) begin
            @(negedge clk);
            chk($sformatf("wr%03h_busy_t%0d", a, k),  32'(bus.busy),   32'd1);
            chk($sformatf("wr%03h_ready_t%0d", a, k), 32'(bus.ready),  32'(k == WL));
            chk($sformatf("wr%03h_rvalid_t%0d", a, k), 32'(bus.rvalid), 32'd0);
        end
        bus.main_write = 1'b0;
        @(negedge clk);
        chk_idle_outputs($sformatf("wr%03h_turn", a));
    endtask

    task automatic do_read(input logic [9:0] a, input logic [3:0][31:0] e);
        @(negedge clk);
        bus.main_read = 1'b1;
        bus.addr      = a;
        for (int k = 1; k <= RL + BW - 1; k++) begin
            @(negedge clk);
            chk($sformatf("rd%03h_busy_t%0d", a, k), 32'(bus.busy), 32'd1);
            if (k < RL) begin
                chk($sformatf("rd%03h_rvalid_t%0d", a, k), 32'(bus.rvalid), 32'd0);
                chk($sformatf("rd%03h_ready_t%0d", a, k),  32'(bus.ready),  32'd0);
            end else begin
                chk($sformatf("rd%03h_rvalid_t%0d", a, k), 32'(bus.rvalid),    32'd1);
                chk($sformatf("rd%03h_idx_t%0d", a, k),    32'(bus.rword_idx), 32'(k - RL));
                chk($sformatf("rd%03h_data_t%0d", a, k),   bus.rdata,          e[k - RL]);
                chk($sformatf("rd%03h_ready_t%0d", a, k),  32'(bus.ready),     32'(k == RL + BW - 1));
            end
        end
        bus.main_read = 1'b0;
        @(negedge clk);
        chk_idle_outputs($sformatf("rd%03h_turn", a));
    endtask

    initial begin
        logic exp_v, exp_b, exp_r;
        logic [3:0][31:0] blk20;

        checks         = 0;
        errors         = 0;
        clk            = 1'b0;
        reset          = 1'b1;
        bus.main_read  = 1'b0;
        bus.main_write = 1'b0;
        bus.addr       = '0;
        bus.wdata      = '0;

        vecs[0]  = mk(1, 10'h010, 32'h10, 0, 0, 0, 0);
        vecs[1]  = mk(1, 10'h011, 32'h11, 0, 0, 0, 0);
        vecs[2]  = mk(1, 10'h012, 32'h12, 0, 0, 0, 0);
        vecs[3]  = mk(1, 10'h013, 32'hDEADBEEF, 0, 0, 0, 0);
        vecs[4]  = mk(0, 10'h012, 0, 32'h10, 32'h11, 32'h12, 32'hDEADBEEF);
        vecs[5]  = mk(1, 10'h020, 32'hA0, 0, 0, 0, 0);
        vecs[6]  = mk(1, 10'h021, 32'hA1, 0, 0, 0, 0);
        vecs[7]  = mk(1, 10'h022, 32'hA2, 0, 0, 0, 0);
        vecs[8]  = mk(1, 10'h023, 32'hA3, 0, 0, 0, 0);
        vecs[9]  = mk(1, 10'h024, 32'hBAD, 0, 0, 0, 0);
        vecs[10] = mk(0, 10'h022, 0, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        vecs[11] = mk(1, 10'h021, 32'h12345678, 0, 0, 0, 0);
        vecs[12] = mk(0, 10'h023, 0, 32'hA0, 32'h12345678, 32'hA2, 32'hA3);
        vecs[13] = mk(1, 10'h004, 32'h4, 0, 0, 0, 0);
        vecs[14] = mk(1, 10'h005, 32'h11, 0, 0, 0, 0);
        vecs[15] = mk(1, 10'h006, 32'h6, 0, 0, 0, 0);
        vecs[16] = mk(1, 10'h007, 32'h7, 0, 0, 0, 0);
        vecs[17] = mk(0, 10'h007, 0, 32'h4, 32'h11, 32'h6, 32'h7);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rdata",  bus.rdata,               32'd0);
        chk("rst_idx",    32'(bus.rword_idx),      32'd0);
        chk("rst_perr",   32'(bus.protocol_err),   32'd0);
        chk_idle_outputs("rst");
        reset = 1'b0;

        // Table-driven writes and block reads
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].wr) do_write(vecs[i].a, vecs[i].d);
            else            do_read(vecs[i].a, vecs[i].e);
        end

        // Request held 3 cycles past ready: second acceptance at ready+2
        blk20[0] = 32'hA0;
        blk20[1] = 32'h12345678;
        blk20[2] = 32'hA2;
        blk20[3] = 32'hA3;
        @(negedge clk);
        bus.main_read = 1'b1;
        bus.addr      = 10'h021;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp_v = (k >= 3 && k <= 6) || (k >= 11 && k <= 14);
            exp_b = (k >= 1 && k <= 6) || (k >= 9 && k <= 14);
            exp_r = (k == 6) || (k == 14);
            chk($sformatf("hold_rvalid_t%0d", k), 32'(bus.rvalid), 32'(exp_v));
            chk($sformatf("hold_busy_t%0d", k),   32'(bus.busy),   32'(exp_b));
            chk($sformatf("hold_ready_t%0d", k),  32'(bus.ready),  32'(exp_r));
            if (exp_v) begin
                chk($sformatf("hold_idx_t%0d", k),  32'(bus.rword_idx), 32'((k < 11) ? k - 3 : k - 11));
                chk($sformatf("hold_data_t%0d", k), bus.rdata, blk20[(k < 11) ? k - 3 : k - 11]);
            end
            if (k == 9) bus.main_read = 1'b0;
        end

        // Simultaneous requests: sticky error, nothing accepted
        chk("perr_before", 32'(bus.protocol_err), 32'd0);
        @(negedge clk);
        bus.main_read  = 1'b1;
        bus.main_write = 1'b1;
        bus.addr       = 10'h013;
        bus.wdata      = 32'hFFFFFFFF;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.main_read  = 1'b0;
                bus.main_write = 1'b0;
            end
            chk($sformatf("both_perr_t%0d", k), 32'(bus.protocol_err), 32'd1);
            chk_idle_outputs($sformatf("both_t%0d", k));
        end
        do_read(10'h012, vecs[4].e);
        chk("perr_sticky", 32'(bus.protocol_err), 32'd1);

        // Reset on the commit edge drops the write
        @(negedge clk);
        bus.main_write = 1'b1;
        bus.addr       = 10'h005;
        bus.wdata      = 32'h55;
        @(negedge clk);
        chk("wrrst_busy_t1",  32'(bus.busy),  32'd1);
        chk("wrrst_ready_t1", 32'(bus.ready), 32'd0);
        reset          = 1'b1;
        bus.main_write = 1'b0;
        @(negedge clk);
        chk("wrrst_rdata", bus.rdata,             32'd0);
        chk("wrrst_idx",   32'(bus.rword_idx),    32'd0);
        chk("wrrst_perr",  32'(bus.protocol_err), 32'd0);
        chk_idle_outputs("wrrst");
        reset = 1'b0;
        do_read(10'h005, vecs[17].e);

        // Reset at the second beat of a burst
        @(negedge clk);
        bus.main_read = 1'b1;
        bus.addr      = 10'h020;
        for (int k = 1; k <= 4; k++) @(negedge clk);
        chk("rdrst_beat1_rvalid", 32'(bus.rvalid),    32'd1);
        chk("rdrst_beat1_idx",    32'(bus.rword_idx), 32'd1);
        chk("rdrst_beat1_data",   bus.rdata,          32'h12345678);
        reset         = 1'b1;
        bus.main_read = 1'b0;
        @(negedge clk);
        chk("rdrst_rdata", bus.rdata,          32'd0);
        chk("rdrst_idx",   32'(bus.rword_idx), 32'd0);
        chk_idle_outputs("rdrst");
        reset = 1'b0;
        do_read(10'h013, vecs[4].e);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
